// File: rtl/pc_unit_if.sv
// Control and status bundle between the PC unit and its pipeline clients
// (hazard unit, decode, CP0).
interface pc_unit_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             br_taken;
   logic [WIDTH-1:0] br_target;
   logic             exc_req;
   logic             eret_req;
   logic [WIDTH-1:0] epc_in;
   logic [WIDTH-1:0] pc_out;
   logic [WIDTH-1:0] pc_plus;
   logic             pend_valid;
   logic             adel;

   modport master (
      output stall, br_taken, br_target, exc_req, eret_req, epc_in,
      input  pc_out, pc_plus, pend_valid, adel
   );

   modport slave (
      input  stall, br_taken, br_target, exc_req, eret_req, epc_in,
      output pc_out, pc_plus, pend_valid, adel
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the pipelined CPU: next-address selection, a one-entry
// buffer for redirects that arrive during a stall, and fetch address checking.
module pc_unit #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_VEC    = 32'h0000_4180,
   parameter int unsigned      STEP       = 4,
   parameter logic [WIDTH-1:0] ADDR_LO    = 32'h0000_3000,
   parameter logic [WIDTH-1:0] ADDR_HI    = 32'h0000_6FFC
) (
   input  logic       clk,
   input  logic       reset,
   pc_unit_if.slave   bus
);
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } pend_state_t;

   pend_state_t      state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH:0]   lo_diff;
   logic [WIDTH:0]   hi_diff;

   assign pc_plus = pc_q + WIDTH'(STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         pc_q    <= RESET_ADDR;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      if (bus.exc_req) begin
         pc_d    = EXC_VEC;
         state_d = EMPTY;
      end else if (bus.eret_req) begin
         pc_d    = bus.epc_in;
         state_d = EMPTY;
      end else if (bus.stall) begin
         // Only the first redirect is kept: it belongs to the oldest instruction.
         if (state_q == EMPTY && bus.br_taken) begin
            tgt_d   = bus.br_target;
            state_d = FULL;
         end
      end else if (state_q == FULL) begin
         pc_d    = tgt_q;
         state_d = EMPTY;
      end else if (bus.br_taken) begin
         pc_d = bus.br_target;
      end else begin
         pc_d = pc_plus;
      end
   end

   // Range checks use the borrow of a widened subtraction so that bounds at
   // the extremes of the address space do not degenerate into constant compares.
   assign lo_diff = {1'b0, pc_q} - {1'b0, ADDR_LO};
   assign hi_diff = {1'b0, ADDR_HI} - {1'b0, pc_q};

   assign bus.pc_out     = pc_q;
   assign bus.pc_plus    = pc_plus;
   assign bus.pend_valid = (state_q == FULL);
   assign bus.adel       = (pc_q[1:0] != 2'b00) || lo_diff[WIDTH] || hi_diff[WIDTH];
endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: default-parameter instance plus a
// full-address-range instance for the wrap case.
module tb_pc_unit;
   logic clk;
   logic reset;
   int   pass_cnt;
   int   total_cnt;

   pc_unit_if #(.WIDTH(32)) bus ();
   pc_unit_if #(.WIDTH(32)) bw ();

   pc_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pc_unit #(
      .WIDTH   (32),
      .ADDR_LO (32'h0000_0000),
      .ADDR_HI (32'hFFFF_FFFC)
   ) dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (bw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.stall     = 1'b1;
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h0000_3100;
      tick();
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3000) $display("FAIL reset_pc: got %h exp %h", bus.pc_out, 32'h0000_3000);
      else pass_cnt++;
      total_cnt++;
      if (bus.pend_valid !== 1'b0) $display("FAIL reset_pend: got %b exp %b", bus.pend_valid, 1'b0);
      else pass_cnt++;
      total_cnt++;
      if (bus.pc_plus !== 32'h0000_3004) $display("FAIL reset_pc_plus: got %h exp %h", bus.pc_plus, 32'h0000_3004);
      else pass_cnt++;
      total_cnt++;
      if (bus.adel !== 1'b0) $display("FAIL reset_adel: got %b exp %b", bus.adel, 1'b0);
      else pass_cnt++;
      reset        = 1'b0;
      bus.stall    = 1'b0;
      bus.br_taken = 1'b0;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3004) $display("FAIL seq_1: got %h exp %h", bus.pc_out, 32'h0000_3004);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3008) $display("FAIL seq_2: got %h exp %h", bus.pc_out, 32'h0000_3008);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_300C) $display("FAIL seq_3: got %h exp %h", bus.pc_out, 32'h0000_300C);
      else pass_cnt++;
      $display("test_reset done, pc=%h", bus.pc_out);
   endtask

   task automatic test_direct_branch();
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h0000_3100;
      tick();
      bus.br_taken  = 1'b0;
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3100) $display("FAIL direct_br: got %h exp %h", bus.pc_out, 32'h0000_3100);
      else pass_cnt++;
      total_cnt++;
      if (bus.pend_valid !== 1'b0) $display("FAIL direct_br_pend: got %b exp %b", bus.pend_valid, 1'b0);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3104) $display("FAIL direct_br_seq: got %h exp %h", bus.pc_out, 32'h0000_3104);
      else pass_cnt++;
      $display("test_direct_branch done, pc=%h", bus.pc_out);
   endtask

   task automatic test_stalled_branch();
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h0000_3010;
      tick();
      // stall cycle 1: first redirect captured
      bus.stall     = 1'b1;
      bus.br_target = 32'h0000_3200;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3010) $display("FAIL stall_hold_1: got %h exp %h", bus.pc_out, 32'h0000_3010);
      else pass_cnt++;
      total_cnt++;
      if (bus.pend_valid !== 1'b1) $display("FAIL stall_pend_1: got %b exp %b", bus.pend_valid, 1'b1);
      else pass_cnt++;
      bus.br_target = 32'h0000_3300;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3010) $display("FAIL stall_hold_2: got %h exp %h", bus.pc_out, 32'h0000_3010);
      else pass_cnt++;
      bus.br_taken = 1'b0;
      tick();
      total_cnt++;
      if (bus.pend_valid !== 1'b1) $display("FAIL stall_pend_3: got %b exp %b", bus.pend_valid, 1'b1);
      else pass_cnt++;
      bus.stall = 1'b0;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3200) $display("FAIL stall_release: got %h exp %h", bus.pc_out, 32'h0000_3200);
      else pass_cnt++;
      total_cnt++;
      if (bus.pend_valid !== 1'b0) $display("FAIL stall_release_pend: got %b exp %b", bus.pend_valid, 1'b0);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3204) $display("FAIL stall_after: got %h exp %h", bus.pc_out, 32'h0000_3204);
      else pass_cnt++;
      // buffered redirect beats a concurrent direct branch on release
      bus.stall     = 1'b1;
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h0000_3400;
      tick();
      bus.stall     = 1'b0;
      bus.br_target = 32'h0000_3500;
      tick();
      bus.br_taken  = 1'b0;
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3400) $display("FAIL pend_vs_br: got %h exp %h", bus.pc_out, 32'h0000_3400);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3404) $display("FAIL pend_vs_br_seq: got %h exp %h", bus.pc_out, 32'h0000_3404);
      else pass_cnt++;
      $display("test_stalled_branch done, pc=%h", bus.pc_out);
   endtask

   task automatic test_exception();
      bus.stall     = 1'b1;
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h0000_3300;
      tick();
      bus.br_taken  = 1'b0;
      total_cnt++;
      if (bus.pend_valid !== 1'b1) $display("FAIL exc_setup_pend: got %b exp %b", bus.pend_valid, 1'b1);
      else pass_cnt++;
      bus.exc_req = 1'b1;
      tick();
      bus.exc_req = 1'b0;
      total_cnt++;
      if (bus.pc_out !== 32'h0000_4180) $display("FAIL exc_pc: got %h exp %h", bus.pc_out, 32'h0000_4180);
      else pass_cnt++;
      total_cnt++;
      if (bus.pend_valid !== 1'b0) $display("FAIL exc_pend: got %b exp %b", bus.pend_valid, 1'b0);
      else pass_cnt++;
      bus.eret_req = 1'b1;
      bus.epc_in   = 32'h0000_3024;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_3024) $display("FAIL eret_pc: got %h exp %h", bus.pc_out, 32'h0000_3024);
      else pass_cnt++;
      bus.exc_req = 1'b1;
      tick();
      bus.exc_req  = 1'b0;
      bus.eret_req = 1'b0;
      total_cnt++;
      if (bus.pc_out !== 32'h0000_4180) $display("FAIL exc_eret_prio: got %h exp %h", bus.pc_out, 32'h0000_4180);
      else pass_cnt++;
      bus.stall = 1'b0;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_4184) $display("FAIL exc_no_stale: got %h exp %h", bus.pc_out, 32'h0000_4184);
      else pass_cnt++;
      $display("test_exception done, pc=%h", bus.pc_out);
   endtask

   task automatic test_adel();
      logic [31:0] tgt [5];
      logic        exp_adel [5];
      tgt[0] = 32'h0000_3002; exp_adel[0] = 1'b1;
      tgt[1] = 32'h0000_7000; exp_adel[1] = 1'b1;
      tgt[2] = 32'h0000_6FFC; exp_adel[2] = 1'b0;
      tgt[3] = 32'h0000_2FFC; exp_adel[3] = 1'b1;
      tgt[4] = 32'h0000_3000; exp_adel[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.br_taken  = 1'b1;
         bus.br_target = tgt[i];
         tick();
         total_cnt++;
         if (bus.pc_out !== tgt[i] || bus.adel !== exp_adel[i])
            $display("FAIL adel_%0d: got pc=%h adel=%b exp pc=%h adel=%b", i, bus.pc_out, bus.adel, tgt[i], exp_adel[i]);
         else pass_cnt++;
      end
      bus.br_target = 32'h0000_6FFC;
      tick();
      bus.br_taken = 1'b0;
      tick();
      total_cnt++;
      if (bus.pc_out !== 32'h0000_7000 || bus.adel !== 1'b1)
         $display("FAIL adel_seq_over: got pc=%h adel=%b exp pc=%h adel=%b", bus.pc_out, bus.adel, 32'h0000_7000, 1'b1);
      else pass_cnt++;
      $display("test_adel done, pc=%h", bus.pc_out);
   endtask

   task automatic test_wrap();
      bw.br_taken  = 1'b1;
      bw.br_target = 32'hFFFF_FFFC;
      tick();
      bw.br_taken  = 1'b0;
      total_cnt++;
      if (bw.pc_out !== 32'hFFFF_FFFC || bw.adel !== 1'b0 || bw.pc_plus !== 32'h0000_0000)
         $display("FAIL wrap_top: got pc=%h adel=%b plus=%h exp pc=%h adel=0 plus=%h", bw.pc_out, bw.adel, bw.pc_plus, 32'hFFFF_FFFC, 32'h0);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bw.pc_out !== 32'h0000_0000 || bw.adel !== 1'b0)
         $display("FAIL wrap_zero: got pc=%h adel=%b exp pc=%h adel=0", bw.pc_out, bw.adel, 32'h0);
      else pass_cnt++;
      $display("test_wrap done, pc=%h", bw.pc_out);
   endtask

   initial begin
      pass_cnt     = 0;
      total_cnt    = 0;
      reset        = 1'b1;
      bus.stall    = 1'b0;
      bus.br_taken = 1'b0;
      bus.br_target = '0;
      bus.exc_req  = 1'b0;
      bus.eret_req = 1'b0;
      bus.epc_in   = '0;
      bw.stall     = 1'b0;
      bw.br_taken  = 1'b0;
      bw.br_target = '0;
      bw.exc_req   = 1'b0;
      bw.eret_req  = 1'b0;
      bw.epc_in    = '0;
      test_reset();
      test_direct_branch();
      test_stalled_branch();
      test_exception();
      test_adel();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the single-cycle PC register, for the pipelined CPU.
- Holds the fetch address.
- Selects the next address from: sequential step, branch/jump redirect, exception vector, or exception return (EPC).
- Buffers a redirect that arrives while fetch is stalled; flags illegal fetch addresses for the CP0 exception logic.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- STEP, 4, sequential increment in bytes.
- ADDR_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- ADDR_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC (hazard unit); redirects arriving during stall are buffered.
- br_taken  input  1  branch/jump redirect request from decode.
- br_target  input  WIDTH  redirect address, valid when br_taken=1.
- exc_req  input  1  exception taken; ignores stall.
- eret_req  input  1  eret executed; ignores stall.
- epc_in  input  WIDTH  return address from CP0, valid when eret_req=1.
- pc_out  output  WIDTH  current fetch address (registered).
- pc_plus  output  WIDTH  pc_out+STEP (combinational; link value).
- pend_valid  output  1  a buffered redirect is waiting (registered).
- adel  output  1  fetch address error (combinational from pc_out).

Behaviour:
- Reset is synchronous, active-high, on clk.
  - On reset: pc_out=RESET_ADDR, pend_valid=0, pending target=0.
  - Reset overrides every other input in that cycle, including a stall or redirect in flight.
  - Outputs after reset: pc_plus=RESET_ADDR+STEP; adel per rule below (0 for defaults).
- Next-PC priority each edge, highest first:
  1. reset
  2. exc_req: pc<=EXC_VEC
  3. eret_req: pc<=epc_in
  4. stall=1: pc holds
  5. pend_valid=1: pc<=pending target
  6. br_taken=1: pc<=br_target
  7. otherwise pc<=pc+STEP
- exc_req and eret_req:
  - Take effect on the next edge regardless of stall.
  - Both clear pend_valid.
  - Simultaneous exc_req and eret_req: exception wins.
- Pending redirect buffer (states EMPTY/FULL, encoded by pend_valid):
  - EMPTY, stall=1, br_taken=1: capture br_target, go to FULL. pc holds.
  - FULL, stall=1: hold; further br_taken ignored (first redirect wins, it belongs to the oldest instruction).
  - FULL, stall=0: pc<=pending target, go to EMPTY. Concurrent br_taken is discarded.
  - EMPTY, stall=0, br_taken=1: direct redirect, 1-cycle latency. The buffer is not used.
- Arithmetic:
  - pc+STEP is modulo 2^WIDTH; 0xFFFF_FFFC+4 wraps to 0x0000_0000, no carry out.
  - Targets are loaded unmodified; no alignment forcing.
- adel=1 when either holds:
  - pc_out[1:0]!=0, or
  - pc_out<ADDR_LO, or pc_out>ADDR_HI (unsigned compare).
  - The PC itself is not altered; the CP0 logic decides whether to raise exc_req.
- Latency: every redirect is visible on pc_out exactly one edge after it is accepted. Buffered redirects appear on the first edge with stall=0.

Test Plan:
- Reset: assert reset 2 cycles with stall=1 and br_taken=1 -> pc_out=0x3000, pend_valid=0, pc_plus=0x3004; release reset -> pc_out 0x3004, 0x3008, 0x300C on successive edges.
- Direct branch: at pc=0x3008 pulse br_taken=1, br_target=0x3100 -> next edge pc_out=0x3100, then 0x3104.
- Stalled branch: at pc=0x3010 raise stall 3 cycles, pulse br_taken with target 0x3200 in cycle 1, then target 0x3300 in cycle 2:
  - pc holds 0x3010; pend_valid=1 from cycle 2.
  - Drop stall -> pc_out=0x3200 (not 0x3300), pend_valid=0.
- Exception during stall with pending redirect: pend_valid=1, stall=1, exc_req=1 -> pc_out=0x4180, pend_valid=0. Then eret_req=1, epc_in=0x3024 -> pc_out=0x3024. exc_req and eret_req together -> 0x4180.
- Address error: br_target=0x3002 -> adel=1 next cycle; br_target=0x7000 -> adel=1; br_target=0x6FFC -> adel=0; br_target=0x2FFC -> adel=1.
- Wrap: instantiate ADDR_LO=0, ADDR_HI=32'hFFFF_FFFC, branch to 0xFFFF_FFFC -> next sequential edge pc_out=0x0000_0000, adel=0.
